// File: rtl/model_state_feedback_matrix_update_if.sv
// model_state_feedback_matrix_update_if: start/ready control plus matrix word streams in and out
interface model_state_feedback_matrix_update_if #(
  parameter int DATA_SIZE = 16
) ();
  logic                 start;
  logic                 ready;
  logic                 data_in_enable;
  logic [DATA_SIZE-1:0] data_in;
  logic                 data_in_ready;
  logic                 data_out_enable;
  logic [DATA_SIZE-1:0] data_out;
  modport slave (
    input  start, data_in_enable, data_in,
    output ready, data_in_ready, data_out_enable, data_out
  );
  modport master (
    output start, data_in_enable, data_in,
    input  ready, data_in_ready, data_out_enable, data_out
  );
endinterface

// File: rtl/model_state_feedback_matrix_update.sv
// model_state_feedback_matrix_update: streams B and K, then emits A - B*K one element at a time
module model_state_feedback_matrix_update #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_SIZE = 8,
  parameter int SIZE_N    = 4,
  parameter int SIZE_P    = 2
) (
  input logic                              clk_i,
  input logic                              rst_ni,
  model_state_feedback_matrix_update_if.slave bus_if
);
  localparam int NP = SIZE_N * SIZE_P;
  localparam int CW = NP > 1 ? $clog2(NP) : 1;
  localparam int IW = SIZE_N > 1 ? $clog2(SIZE_N) : 1;
  localparam int KW = SIZE_P > 1 ? $clog2(SIZE_P) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_K, LOAD_A, MAC, EMIT, DONE} state_e;
  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] b_mem [2**CW];
  logic [DATA_SIZE-1:0] k_mem [2**CW];
  logic [CW-1:0]        cnt_q, cnt_d, b_idx, k_idx;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic [KW-1:0]        k_q, k_d;
  logic [DATA_SIZE-1:0] acc_q, acc_d, dout_q, dout_d, term;
  logic                 doe_q, doe_d, rdy_q, rdy_d;
  logic                 in_rdy, take, we_b, we_k;
  assign in_rdy                 = state_q inside {LOAD_B, LOAD_K, LOAD_A};
  assign take                   = bus_if.data_in_enable && in_rdy;
  assign bus_if.data_in_ready   = in_rdy;
  assign bus_if.data_out_enable = doe_q;
  assign bus_if.data_out        = dout_q;
  assign bus_if.ready           = rdy_q;
  assign b_idx = CW'(int'(i_q) * SIZE_P + int'(k_q));
  assign k_idx = CW'(int'(k_q) * SIZE_N + int'(j_q));
  // full-width signed product, arithmetic shift back to Q format, then truncate
  assign term = DATA_SIZE'(((2*DATA_SIZE)'($signed(b_mem[b_idx])) *
                            (2*DATA_SIZE)'($signed(k_mem[k_idx]))) >>> FRAC_SIZE);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    doe_d   = 1'b0;
    rdy_d   = 1'b0;
    we_b    = 1'b0;
    we_k    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = bus_if.start ? LOAD_B : IDLE;
        cnt_d   = '0;
        i_d     = '0;
        j_d     = '0;
      end
      LOAD_B: if (take) begin
        we_b    = 1'b1;
        cnt_d   = cnt_q == CW'(NP - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(NP - 1) ? LOAD_K : LOAD_B;
      end
      LOAD_K: if (take) begin
        we_k    = 1'b1;
        cnt_d   = cnt_q == CW'(NP - 1) ? '0 : cnt_q + CW'(1);
        state_d = cnt_q == CW'(NP - 1) ? LOAD_A : LOAD_K;
        i_d     = '0;
        j_d     = '0;
      end
      LOAD_A: if (take) begin
        acc_d   = bus_if.data_in;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d   = acc_q - term;
        k_d     = k_q + KW'(1);
        state_d = k_q == KW'(SIZE_P - 1) ? EMIT : MAC;
      end
      EMIT: begin
        dout_d  = acc_q;
        doe_d   = 1'b1;
        j_d     = j_q == IW'(SIZE_N - 1) ? '0 : j_q + IW'(1);
        i_d     = j_q == IW'(SIZE_N - 1) ? i_q + IW'(1) : i_q;
        state_d = (i_q == IW'(SIZE_N - 1) && j_q == IW'(SIZE_N - 1)) ? DONE : LOAD_A;
      end
      DONE: begin
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
      rdy_q   <= rdy_d;
    end
  end
  // coefficient storage is deliberately left unreset; every operation reloads it
  always_ff @(posedge clk_i) begin
    if (we_b) b_mem[cnt_q] <= bus_if.data_in;
    if (we_k) k_mem[cnt_q] <= bus_if.data_in;
  end
endmodule

// File: tb/tb_model_state_feedback_matrix_update.sv
// tb_model_state_feedback_matrix_update: randomized stimulus checked against a matrix-level model of A - B*K
module tb_model_state_feedback_matrix_update;
  localparam int DW = 16;
  localparam int FR = 8;
  localparam int N  = 4;
  localparam int P  = 2;
  localparam int NW = 2 * N * P + N * N;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  model_state_feedback_matrix_update_if #(.DATA_SIZE(DW)) bus ();
  model_state_feedback_matrix_update #(
    .DATA_SIZE(DW), .FRAC_SIZE(FR), .SIZE_N(N), .SIZE_P(P)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_if(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_cnt = 0;
  int ready_cyc = 0;
  logic [DW-1:0] bm [N*P];
  logic [DW-1:0] km [P*N];
  logic [DW-1:0] am [N*N];
  logic [DW-1:0] expv [N*N];
  logic [DW-1:0] outq [$];
  int out_cyc [$];
  int acc_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.data_out_enable) begin
      outq.push_back(bus.data_out);
      out_cyc.push_back(cyc);
    end
    if (bus.ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
  end
  // element (i,j) = A[i][j] minus the sum of Q-format products, reduced modulo 2^DW
  function automatic void model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint v = longint'($signed(am[i*N+j]));
        for (int k = 0; k < P; k++) begin
          longint p = longint'($signed(bm[i*P+k])) * longint'($signed(km[k*N+j]));
          v = v - (p >>> FR);
        end
        expv[i*N+j] = DW'(v);
      end
  endfunction
  function automatic void randomize_mats();
    foreach (bm[e]) bm[e] = DW'($urandom);
    foreach (km[e]) km[e] = DW'($urandom);
    foreach (am[e]) am[e] = DW'($urandom);
  endfunction
  task automatic drive_op(input bit gaps, input bit junk, input bit mid_start, input int limit, output bit ok);
    logic [DW-1:0] w [$];
    int idx = 0;
    foreach (bm[e]) w.push_back(bm[e]);
    foreach (km[e]) w.push_back(km[e]);
    foreach (am[e]) w.push_back(am[e]);
    outq.delete();
    out_cyc.delete();
    acc_cyc.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 4000 && idx < limit; c++) begin
      bit dir = bus.data_in_ready;
      bit take;
      bus.data_in_enable = dir ? (gaps ? 1'($urandom_range(0, 1)) : 1'b1) : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.data_in = dir ? w[idx] : DW'($urandom);
      bus.start = mid_start && idx == N * P + 2;
      take = dir && bus.data_in_enable;
      if (take && idx >= 2 * N * P) acc_cyc.push_back(cyc);
      @(negedge clk);
      if (take) idx++;
    end
    bus.data_in_enable = 1'b0;
    bus.start = 1'b0;
    ok = idx == limit;
  endtask
  task automatic wait_done(input int rc0);
    for (int n = 0; n < 400 && ready_cnt == rc0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset();
    bit ok;
    int rc0;
    #1;
    n_chk += 4;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    if (bus.data_out_enable !== 1'b0) begin n_fail++; $display("FAIL reset_doe: got %b want 0", bus.data_out_enable); end
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", bus.data_out); end
    if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b want 0", bus.data_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    randomize_mats();
    foreach (am[e]) am[e] = 16'h4000 | DW'(e);
    rc0 = ready_cnt;
    drive_op(1'b0, 1'b0, 1'b0, 2 * N * P + 3, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL abort_load: timed out before third A word"); end
    rst_n = 1'b0;
    #1;
    n_chk += 4;
    if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b want 0", bus.ready); end
    if (bus.data_out_enable !== 1'b0) begin n_fail++; $display("FAIL abort_doe: got %b want 0", bus.data_out_enable); end
    if (bus.data_out !== '0) begin n_fail++; $display("FAIL abort_dout: got %h want 0", bus.data_out); end
    if (bus.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_dir: got %b want 0", bus.data_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_chk += 2;
    if (outq.size() != 2) begin n_fail++; $display("FAIL abort_outputs: got %0d pulses want 2", outq.size()); end
    if (ready_cnt != rc0) begin n_fail++; $display("FAIL abort_no_ready: got %0d ready pulses want 0", ready_cnt - rc0); end
    randomize_mats();
    model();
    rc0 = ready_cnt;
    drive_op(1'b0, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 2;
    if (!ok) begin n_fail++; $display("FAIL reload_load: input stream stalled"); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL reload_count: got %0d want %0d", outq.size(), N * N); end
    foreach (outq[e]) if (e < N * N) begin
      n_chk++;
      if (outq[e] !== expv[e]) begin n_fail++; $display("FAIL reload_out[%0d]: got %h want %h", e, outq[e], expv[e]); end
    end
  endtask
  task automatic test_basic();
    bit ok;
    int rc0 = ready_cnt;
    foreach (bm[e]) bm[e] = 16'd256;
    foreach (km[e]) km[e] = 16'd256;
    foreach (am[e]) am[e] = 16'd1024;
    drive_op(1'b0, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 3;
    if (!ok) begin n_fail++; $display("FAIL basic_load: input stream stalled"); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", outq.size(), N * N); end
    if (ready_cnt != rc0 + 1) begin n_fail++; $display("FAIL basic_ready: got %0d pulses want 1", ready_cnt - rc0); end
    foreach (outq[e]) begin
      n_chk++;
      if (outq[e] !== 16'd512) begin n_fail++; $display("FAIL basic_out[%0d]: got %h want 0200", e, outq[e]); end
    end
  endtask
  task automatic test_signed();
    bit ok;
    int rc0 = ready_cnt;
    foreach (bm[e]) bm[e] = '0;
    foreach (km[e]) km[e] = '0;
    foreach (am[e]) am[e] = DW'($urandom);
    bm[0] = 16'hFF00;
    km[0] = 16'd512;
    am[0] = 16'd100;
    drive_op(1'b1, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 2;
    if (!ok) begin n_fail++; $display("FAIL signed_load: input stream stalled"); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL signed_count: got %0d want %0d", outq.size(), N * N); end
    foreach (outq[e]) if (e < N * N) begin
      logic [DW-1:0] want = e == 0 ? 16'd612 : am[e];
      n_chk++;
      if (outq[e] !== want) begin n_fail++; $display("FAIL signed_out[%0d]: got %h want %h", e, outq[e], want); end
    end
  endtask
  task automatic test_wrap();
    bit ok;
    int rc0 = ready_cnt;
    foreach (bm[e]) bm[e] = '0;
    foreach (km[e]) km[e] = '0;
    foreach (am[e]) am[e] = DW'($urandom);
    bm[0] = 16'hFF00;
    km[0] = 16'd256;
    am[0] = 16'h7FFF;
    drive_op(1'b0, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 3;
    if (!ok) begin n_fail++; $display("FAIL wrap_load: input stream stalled"); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", outq.size(), N * N); end
    else if (outq[0] !== 16'h80FF) begin n_fail++; $display("FAIL wrap_out0: got %h want 80ff", outq[0]); end
  endtask
  task automatic test_handshake();
    for (int r = 0; r < 3; r++) begin
      bit ok;
      int rc0 = ready_cnt;
      randomize_mats();
      model();
      drive_op(1'b1, 1'b1, 1'b1, NW, ok);
      wait_done(rc0);
      n_chk += 3;
      if (!ok) begin n_fail++; $display("FAIL hs_load[%0d]: input stream stalled", r); end
      if (outq.size() != N * N) begin n_fail++; $display("FAIL hs_count[%0d]: got %0d want %0d", r, outq.size(), N * N); end
      if (ready_cnt != rc0 + 1) begin n_fail++; $display("FAIL hs_ready[%0d]: got %0d pulses want 1", r, ready_cnt - rc0); end
      foreach (outq[e]) if (e < N * N) begin
        n_chk++;
        if (outq[e] !== expv[e]) begin n_fail++; $display("FAIL hs_out[%0d][%0d]: got %h want %h", r, e, outq[e], expv[e]); end
      end
    end
  endtask
  task automatic test_latency();
    bit ok;
    int rc0 = ready_cnt;
    randomize_mats();
    drive_op(1'b1, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 2;
    if (!ok) begin n_fail++; $display("FAIL lat_load: input stream stalled"); end
    if (out_cyc.size() != N * N || acc_cyc.size() != N * N) begin
      n_fail++;
      $display("FAIL lat_sizes: got %0d outputs %0d accepts want %0d", out_cyc.size(), acc_cyc.size(), N * N);
    end else begin
      for (int e = 0; e < N * N; e++) begin
        n_chk++;
        if (out_cyc[e] != acc_cyc[e] + P + 2) begin
          n_fail++;
          $display("FAIL lat_out[%0d]: got %0d cycles want %0d", e, out_cyc[e] - acc_cyc[e], P + 2);
        end
      end
      n_chk++;
      if (ready_cyc != out_cyc[N*N-1] + 1) begin
        n_fail++;
        $display("FAIL lat_ready: got %0d cycles after last output want 1", ready_cyc - out_cyc[N*N-1]);
      end
    end
  endtask
  task automatic test_back_to_back();
    bit ok;
    int rc0 = ready_cnt;
    randomize_mats();
    model();
    drive_op(1'b0, 1'b0, 1'b0, NW, ok);
    for (int n = 0; n < 400 && !bus.ready; n++) @(negedge clk);
    n_chk += 3;
    if (!ok) begin n_fail++; $display("FAIL b2b_load1: input stream stalled"); end
    if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %b want 1", bus.ready); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL b2b_count1: got %0d want %0d", outq.size(), N * N); end
    else if (outq[N*N-1] !== expv[N*N-1]) begin
      n_fail++;
      $display("FAIL b2b_last1: got %h want %h", outq[N*N-1], expv[N*N-1]);
    end
    randomize_mats();
    model();
    rc0 = ready_cnt + 1;
    drive_op(1'b0, 1'b0, 1'b0, NW, ok);
    wait_done(rc0);
    n_chk += 3;
    if (!ok) begin n_fail++; $display("FAIL b2b_load2: START after READY not honoured"); end
    if (outq.size() != N * N) begin n_fail++; $display("FAIL b2b_count2: got %0d want %0d", outq.size(), N * N); end
    if (ready_cnt != rc0 + 1) begin n_fail++; $display("FAIL b2b_ready2: got %0d pulses want 1", ready_cnt - rc0); end
    foreach (outq[e]) if (e < N * N) begin
      n_chk++;
      if (outq[e] !== expv[e]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", e, outq[e], expv[e]); end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.data_in_enable = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_handshake();
    test_latency();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
